// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter in front of a single-port DEPTH x DATA_WIDTH memory.
// Optional macro MEM_ARB_RANGE_CHECK_EN: addr >= DEPTH is discarded (write) or flagged on rsp_err (read).
module mem_arb #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DEPTH      = 1 << ADDR_WIDTH,
   parameter int unsigned NUM_PORTS  = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS-1:0]             req_valid,
   output logic [NUM_PORTS-1:0]             req_ready,
   input  logic [NUM_PORTS-1:0]             req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]             rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata
`ifdef MEM_ARB_RANGE_CHECK_EN
   ,
   output logic                             rsp_err
`endif
);

   localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      ptr_nxt_c;
   logic [PTR_W-1:0]      gnt_c;
   logic                  gnt_any_c;
   int unsigned           cand_c;
   logic [ADDR_WIDTH-1:0] sel_addr_c;
   logic [DATA_WIDTH-1:0] sel_wdata_c;
   logic                  sel_write_c;
   logic                  in_range_c;
   logic [IDX_W-1:0]      idx_c;
   logic [NUM_PORTS-1:0]  rd_hit_c;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // First requester at or after ptr, wrapping; nothing is granted while in reset
   always_comb begin
      gnt_c     = '0;
      gnt_any_c = 1'b0;
      cand_c    = 0;
      if (rst_n) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand_c = (32'(ptr) + i) % NUM_PORTS;
            if (!gnt_any_c && req_valid[PTR_W'(cand_c)]) begin
               gnt_any_c = 1'b1;
               gnt_c     = PTR_W'(cand_c);
            end
         end
      end
   end

   // Payload of the granted port; other ports' payloads never reach the memory
   always_comb begin
      req_ready   = '0;
      sel_addr_c  = '0;
      sel_wdata_c = '0;
      sel_write_c = 1'b0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (gnt_any_c && (gnt_c == PTR_W'(p))) begin
            req_ready[p] = 1'b1;
            sel_addr_c   = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata_c  = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            sel_write_c  = req_write[p];
         end
      end
   end

   assign ptr_nxt_c = (gnt_c == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_c + 1'b1;
   assign rd_hit_c  = req_ready & {NUM_PORTS{~sel_write_c}};

`ifdef MEM_ARB_RANGE_CHECK_EN
   assign in_range_c = ({1'b0, sel_addr_c} < DEPTH_X);
   assign idx_c      = IDX_W'(sel_addr_c);
`else
   assign in_range_c = 1'b1;
   assign idx_c      = IDX_W'({1'b0, sel_addr_c} % DEPTH_X);
`endif

   // Arbitration pointer and one-cycle read response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
`ifdef MEM_ARB_RANGE_CHECK_EN
         rsp_err   <= 1'b0;
`endif
      end else begin
         if (gnt_any_c) ptr <= ptr_nxt_c;
         rsp_valid <= rd_hit_c;
         rsp_rdata <= ((|rd_hit_c) && in_range_c) ? mem[idx_c] : '0;
`ifdef MEM_ARB_RANGE_CHECK_EN
         rsp_err   <= (|rd_hit_c) && !in_range_c;
`endif
      end
   end

   // Storage is deliberately not reset so contents survive rst_n
   always_ff @(posedge clk) begin
      if (gnt_any_c && sel_write_c && in_range_c) mem[idx_c] <= sel_wdata_c;
   end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed and random stimulus for mem_arb against a behavioural model.
// Compiles with or without MEM_ARB_RANGE_CHECK_EN.
module tb_mem_arb;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 16;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned NP    = 4;
`ifdef MEM_ARB_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic [NP-1:0]     req_valid;
   logic [NP-1:0]     req_ready;
   logic [NP-1:0]     req_write;
   logic [NP*AW-1:0]  req_addr;
   logic [NP*DW-1:0]  req_wdata;
   logic [NP-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_rdata;
`ifdef MEM_ARB_RANGE_CHECK_EN
   logic              rsp_err;
`endif

   mem_arb #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .NUM_PORTS  (NP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata)
`ifdef MEM_ARB_RANGE_CHECK_EN
      ,
      .rsp_err   (rsp_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [DW-1:0] mmem   [DEPTH];
   bit            mknown [DEPTH];
   int            mptr;
   int            total;
   int            bad;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_in_range(input int a);
      return !RANGE_EN || (a < int'(DEPTH));
   endfunction

   task automatic set_req(input int p, input bit v, input bit w, input int a, input int d);
      req_valid[p]           = v;
      req_write[p]           = w;
      req_addr[p*AW +: AW]   = AW'(a);
      req_wdata[p*DW +: DW]  = DW'(d);
   endtask

   // one clock: check grant before the edge, then the response after it
   task automatic step(output int g);
      logic [NP-1:0] exp_rdy;
      logic [NP-1:0] exp_vld;
      logic [DW-1:0] exp_dat;
      bit            exp_err;
      bit            dat_known;
      int            a;
      int            m;
      g = -1;
      @(negedge clk);
      if (rst_n) begin
         for (int k = 0; k < int'(NP); k++) begin
            int p;
            p = (mptr + k) % NP;
            if (g < 0 && req_valid[p]) g = p;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      exp_vld   = '0;
      exp_dat   = '0;
      exp_err   = 1'b0;
      dat_known = 1'b1;
      if (g >= 0) begin
         mptr = (g + 1) % NP;
         a    = int'(req_addr[g*AW +: AW]);
         m    = a % DEPTH;
         if (req_write[g]) begin
            if (m_in_range(a)) begin
               mmem[m]   = req_wdata[g*DW +: DW];
               mknown[m] = 1'b1;
            end
         end else begin
            exp_vld[g] = 1'b1;
            if (m_in_range(a)) begin
               exp_dat   = mmem[m];
               dat_known = mknown[m];
            end else begin
               exp_err = 1'b1;
            end
         end
      end
      check("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
      if (dat_known || exp_err) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_dat));
`ifdef MEM_ARB_RANGE_CHECK_EN
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
`endif
   endtask

   function automatic int rand_addr();
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(256, 65535));
      return int'($urandom_range(0, 47));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int cnt [NP];
      total     = 0;
      bad       = 0;
      mptr      = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;

      // reset holds everything quiet even with all ports requesting
      @(negedge clk);
      for (int p = 0; p < int'(NP); p++) set_req(p, 1'b1, 1'b1, p, 8'hEE);
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
`ifdef MEM_ARB_RANGE_CHECK_EN
      check("rst_rsp_err", 32'(rsp_err), 32'h0);
`endif
      req_valid = '0;
      rst_n     = 1'b1;

      // write then read back on port 0
      set_req(0, 1'b1, 1'b1, 'h0010, 'hA5);
      step(g);
      check("wr_gnt", 32'(g), 32'd0);
      set_req(0, 1'b1, 1'b0, 'h0010, 0);
      step(g);
      check("rd_valid", 32'(rsp_valid), 32'h1);
      check("rd_data", 32'(rsp_rdata), 32'hA5);

      // cross-port write/read at 0x0100, with 0x0000 as an aliasing witness
      set_req(0, 1'b1, 1'b1, 'h0000, 'h5A);
      step(g);
      set_req(0, 1'b0, 1'b0, 0, 0);
      set_req(1, 1'b1, 1'b1, 'h0100, 'h3C);
      step(g);
      check("xp_wr_gnt", 32'(g), 32'd1);
      set_req(1, 1'b0, 1'b0, 0, 0);
      set_req(0, 1'b1, 1'b0, 'h0100, 0);
      step(g);
      check("xp_rd_valid", 32'(rsp_valid), 32'h1);
      check("xp_rd_data", 32'(rsp_rdata), RANGE_EN ? 32'h00 : 32'h3C);
`ifdef MEM_ARB_RANGE_CHECK_EN
      check("oor_err", 32'(rsp_err), 32'h1);
`endif
      set_req(0, 1'b1, 1'b0, 'h0000, 0);
      step(g);
      check("alias_data", 32'(rsp_rdata), RANGE_EN ? 32'h5A : 32'h3C);
`ifdef MEM_ARB_RANGE_CHECK_EN
      check("inrange_err", 32'(rsp_err), 32'h0);
`endif
      set_req(0, 1'b0, 1'b0, 0, 0);
      step(g);
      check("idle_gnt", 32'(g), 32'hFFFF_FFFF);

      // two ports requesting continuously alternate (ptr is 1 here)
      set_req(0, 1'b1, 1'b0, 'h0010, 0);
      set_req(1, 1'b1, 1'b0, 'h0000, 0);
      for (int k = 0; k < 6; k++) begin
         step(g);
         check("alt_gnt", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      set_req(0, 1'b0, 1'b0, 0, 0);

      // ptr=2 with ports 1 and 3 requesting: 3 first, then 1
      step(g);
      check("ptr2_setup", 32'(g), 32'd1);
      set_req(3, 1'b1, 1'b0, 'h0000, 0);
      step(g);
      check("ptr2_first", 32'(g), 32'd3);
      step(g);
      check("ptr2_second", 32'(g), 32'd1);

      // all four ports continuously: each granted twice in eight cycles
      for (int p = 0; p < int'(NP); p++) begin
         set_req(p, 1'b1, 1'b0, 'h0010, 0);
         cnt[p] = 0;
      end
      for (int k = 0; k < 2 * int'(NP); k++) begin
         step(g);
         if (g >= 0) cnt[g]++;
      end
      for (int p = 0; p < int'(NP); p++) check("fair_cnt", 32'(cnt[p]), 32'd2);
      req_valid = '0;

      // reset lands on a read in flight; response dropped, data preserved
      set_req(2, 1'b1, 1'b0, 'h0010, 0);
      @(negedge clk);
      check("inflight_ready", 32'(req_ready), 32'h4);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("inflight_valid", 32'(rsp_valid), 32'h0);
      check("inflight_rdata", 32'(rsp_rdata), 32'h0);
      check("inflight_ready_rst", 32'(req_ready), 32'h0);
      #1;
      mptr = 0;
      set_req(2, 1'b0, 1'b0, 0, 0);
      set_req(0, 1'b1, 1'b0, 'h0010, 0);
      rst_n = 1'b1;
      step(g);
      check("post_rst_gnt", 32'(g), 32'd0);
      check("post_rst_data", 32'(rsp_rdata), 32'hA5);
      set_req(0, 1'b0, 1'b0, 0, 0);
      step(g);

      // random traffic; pending requests are held until granted
      for (int n = 0; n < 500; n++) begin
         for (int p = 0; p < int'(NP); p++) begin
            if (!req_valid[p]) begin
               set_req(p, ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
                       rand_addr(), int'($urandom_range(0, 255)));
            end
         end
         step(g);
         if (g >= 0) req_valid[g] = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 1<<ADDR_WIDTH, number of implemented words (1..1<<ADDR_WIDTH).
REQ-004 SHALL have parameter NUM_PORTS, default 2, requester channel count (1..8).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port req_valid  input  NUM_PORTS  per-port request valid.
REQ-008 SHALL have port req_ready  output  NUM_PORTS  per-port request accepted this cycle.
REQ-009 SHALL have port req_write  input  NUM_PORTS  per-port 1=write, 0=read.
REQ-010 SHALL have port req_addr  input  NUM_PORTS*ADDR_WIDTH  packed per-port address, port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port req_wdata  input  NUM_PORTS*DATA_WIDTH  packed per-port write data, same packing.
REQ-012 SHALL have port rsp_valid  output  NUM_PORTS  per-port read response valid, one-hot or zero.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  shared read data, valid when any rsp_valid bit set.
REQ-014 SHALL have port rsp_err  output  1  out-of-range flag (present only with MEM_ARB_RANGE_CHECK_EN).

Function
- REQ-015 SHALL hold a single-port array of DEPTH x DATA_WIDTH; at most one access per clk cycle.
- REQ-016 SHALL arbitrate round-robin: grant the first requesting port at or after pointer ptr, wrapping modulo NUM_PORTS.
- REQ-017 SHALL assert req_ready combinationally for exactly the granted port only; zero when no req_valid set.
- REQ-018 SHALL update ptr to (granted port + 1) mod NUM_PORTS on each grant; ptr unchanged with no grant.
- REQ-019 SHALL perform an accepted write at the rising edge of the accept cycle; no response generated.
- REQ-020 SHALL return an accepted read with latency 1: rsp_valid[p] high for exactly the following cycle with rsp_rdata = memory[addr].
- REQ-021 SHALL return pre-write data for a read in cycle N+1 after a write to the same address in cycle N? No: a read accepted in N+1 SHALL see the write accepted in N.
- REQ-022 SHALL drive rsp_rdata to 0 when no rsp_valid bit set; no tri-state outputs.
- REQ-023 SHALL allow back-to-back accepts on consecutive cycles, from the same or different ports (full throughput).
- REQ-024 SHALL treat a request held valid but not granted as pending; requester holds addr/data/write stable until req_ready.
- REQ-025 SHALL, with all NUM_PORTS requesting continuously, grant each port exactly once per NUM_PORTS cycles.
- REQ-026 SHALL ignore req_write/req_addr/req_wdata of non-granted ports.

Reset
- REQ-027 SHALL, while rst_n low, force rsp_valid=0, rsp_rdata=0, rsp_err=0, ptr=0, req_ready=0.
- REQ-028 SHALL drop any read in flight when reset asserts mid-operation; no response after reset release.
- REQ-029 SHALL NOT clear array contents on reset; contents after reset equal contents before.
- REQ-030 SHALL accept requests from the first rising edge after rst_n deasserts.

Configuration
- REQ-031 SHALL use macro MEM_ARB_RANGE_CHECK_EN.
- REQ-032 With macro defined: access with addr >= DEPTH SHALL be accepted normally, write SHALL be discarded, read SHALL return rsp_rdata=0 with rsp_err=1 in the response cycle; rsp_err=0 otherwise.
- REQ-033 Without macro: rsp_err port absent; address used modulo DEPTH (low bits when DEPTH is power of two, else addr % DEPTH).

Verification
- REQ-034 Reset, port0 write addr 0x0010 data 0xA5, next cycle port0 read 0x0010 -> rsp_valid=01 one cycle later, rsp_rdata=0xA5.
- REQ-035 NUM_PORTS=2, both ports request continuously from reset -> grants 0,1,0,1; ptr alternates; no starvation.
- REQ-036 Port1 write 0x0100=0x3C cycle N, port0 read 0x0100 cycle N+1 -> rsp_valid=01, rsp_rdata=0x3C in N+2.
- REQ-037 Read accepted, rst_n pulsed low before response edge -> rsp_valid stays 0; array data at that address unchanged after release.
- REQ-038 MEM_ARB_RANGE_CHECK_EN, DEPTH=256, read addr 0x0100 -> rsp_rdata=0x00, rsp_err=1; write 0x0100=0xFF then read 0x0000 -> original value returned, rsp_err=0.
- REQ-039 NUM_PORTS=4, ports 1 and 3 requesting, ptr=2 -> port3 granted first, then port1.
